// File: rtl/alu_pkg.sv
// Shared opcode encodings for the registered integer ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBB = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: maps opcode and operands to the next primary
// and secondary results; the wrapper registers them.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic [WIDTH-1:0] next_out,
    output logic [WIDTH-1:0] next_extra
);

    logic             add_cin;
    logic             sub_cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [2*WIDTH-1:0] shl_wide;
    logic [2*WIDTH-1:0] shr_wide;

    // Carry/borrow input only participates in ADDC and SUBB, so the plain
    // forms share the same adder and subtractor with a forced-zero carry.
    assign add_cin = (opcode == OP_ADDC) & carryin;
    assign sub_cin = (opcode == OP_SUBB) & carryin;

    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    // A true result below zero wraps into the top bit, which is the borrow.
    assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_cin};
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign quo = (b == '0) ? '1 : a / b;
    assign rem = (b == '0) ? a  : a % b;

    // Shifting past the full double-width window leaves zero in both halves.
    assign shl_wide = {{WIDTH{1'b0}}, a} << b;
    assign shr_wide = {a, {WIDTH{1'b0}}} >> b;

    always_comb begin
        next_out   = '0;
        next_extra = '0;
        case (opcode)
            OP_ADD, OP_ADDC: begin
                next_out   = sum[WIDTH-1:0];
                next_extra = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            end
            OP_SUB, OP_SUBB: begin
                next_out   = diff[WIDTH-1:0];
                next_extra = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            end
            OP_MUL: begin
                next_out   = prod[WIDTH-1:0];
                next_extra = prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                next_out   = quo;
                next_extra = rem;
            end
            OP_AND: next_out = a & b;
            OP_OR:  next_out = a | b;
            OP_XOR: next_out = a ^ b;
            OP_NOT: next_out = ~a;
            OP_SHL: begin
                next_out   = shl_wide[WIDTH-1:0];
                next_extra = shl_wide[2*WIDTH-1:WIDTH];
            end
            OP_SHR: begin
                next_out   = shr_wide[2*WIDTH-1:WIDTH];
                next_extra = shr_wide[WIDTH-1:0];
            end
            default: begin
                next_out   = '0;
                next_extra = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered integer ALU: one-cycle latency, full throughput, no handshake.
// Every edge samples the inputs; results are visible after that edge.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] extra
);

    logic [WIDTH-1:0] next_out;
    logic [WIDTH-1:0] next_extra;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .carryin   (carryin),
        .next_out  (next_out),
        .next_extra(next_extra)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            extra <= '0;
        end else begin
            out   <= next_out;
            extra <= next_extra;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors plus random traffic through
// a scoreboard queue checked one edge after each stimulus.
module tb_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carryin;
    logic [W-1:0] out;
    logic [W-1:0] extra;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] exp_q[$];
    string          tag_q[$];

    alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .carryin(carryin),
        .out    (out),
        .extra  (extra)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Independent reference using 64-bit host arithmetic.
    function automatic logic [2*W-1:0] model(input logic [3:0] op, input logic [W-1:0] ma,
                                             input logic [W-1:0] mb, input logic mc);
        longint unsigned x, y, r;
        logic [W-1:0] ro, re;
        x = {32'd0, ma};
        y = {32'd0, mb};
        ro = '0;
        re = '0;
        case (op)
            4'd0: begin r = x + y; ro = r[31:0]; re = {31'd0, r[32]}; end
            4'd1: begin r = x + y + longint'(mc); ro = r[31:0]; re = {31'd0, r[32]}; end
            4'd2: begin ro = ma - mb; re = {31'd0, x < y}; end
            4'd3: begin ro = ma - mb - {31'd0, mc}; re = {31'd0, x < (y + longint'(mc))}; end
            4'd4: begin r = x * y; ro = r[31:0]; re = r[63:32]; end
            4'd5: begin
                if (mb == 0) begin ro = 32'hFFFF_FFFF; re = ma; end
                else begin ro = ma / mb; re = ma % mb; end
            end
            4'd6: ro = ma & mb;
            4'd7: ro = ma | mb;
            4'd8: ro = ma ^ mb;
            4'd9: ro = ~ma;
            4'd10: if (y < 64) begin r = x << y; ro = r[31:0]; re = r[63:32]; end
            4'd11: if (y < 64) begin r = (x << 32) >> y; ro = r[63:32]; re = r[31:0]; end
            default: begin ro = '0; re = '0; end
        endcase
        return {ro, re};
    endfunction

    task automatic drive(input string tag, input logic r, input logic [3:0] op,
                         input logic [W-1:0] da, input logic [W-1:0] db, input logic dc,
                         input logic [W-1:0] eo, input logic [W-1:0] ee);
        @(negedge clk);
        rst     = r;
        opcode  = op;
        a       = da;
        b       = db;
        carryin = dc;
        exp_q.push_back({eo, ee});
        tag_q.push_back(tag);
    endtask

    task automatic drive_model(input string tag, input logic [3:0] op, input logic [W-1:0] da,
                               input logic [W-1:0] db, input logic dc);
        logic [2*W-1:0] e;
        e = model(op, da, db, dc);
        drive(tag, 1'b0, op, da, db, dc, e[2*W-1:W], e[W-1:0]);
    endtask

    // Each entry is checked just after the edge that sampled its inputs.
    always @(posedge clk) begin
        logic [2*W-1:0] e;
        string t;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, ".out"}, out, e[2*W-1:W]);
            check({t, ".extra"}, extra, e[W-1:0]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] ra, rb;
        rst = 1'b1; opcode = '0; a = '0; b = '0; carryin = 1'b0;

        drive("reset0", 1'b1, 4'd0, 32'h1234_5678, 32'h1, 1'b1, 32'h0, 32'h0);
        drive("reset1", 1'b1, 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);

        drive("add",    1'b0, 4'd0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 32'h0);
        drive("addc",   1'b0, 4'd1, 32'h6666_6666, 32'h6666_6666, 1'b1, 32'hCCCC_CCCD, 32'h0);
        drive("addcy",  1'b0, 4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 32'h1);
        drive("addcin", 1'b0, 4'd0, 32'h1, 32'h1, 1'b1, 32'h2, 32'h0);
        drive("sub",    1'b0, 4'd2, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'h5555_5555, 32'h0);
        drive("subb",   1'b0, 4'd3, 32'h6666_6666, 32'h6666_6666, 1'b1, 32'hFFFF_FFFF, 32'h1);
        drive("subbor", 1'b0, 4'd2, 32'h1, 32'h2, 1'b1, 32'hFFFF_FFFF, 32'h1);
        drive("mul",    1'b0, 4'd4, 32'hFFFF_FFFF, 32'h2, 1'b0, 32'hFFFF_FFFE, 32'h1);
        drive("div",    1'b0, 4'd5, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'h2, 32'h0);
        drive("div0",   1'b0, 4'd5, 32'h7, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h7);
        drive("and",    1'b0, 4'd6, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'h0, 32'h0);
        drive("or",     1'b0, 4'd7, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 32'h0);
        drive("xor",    1'b0, 4'd8, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 32'h0);
        drive("not",    1'b0, 4'd9, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h5555_5555, 32'h0);
        drive("xorsame",1'b0, 4'd8, 32'h6666_6666, 32'h6666_6666, 1'b0, 32'h0, 32'h0);
        drive("shl",    1'b0, 4'd10, 32'h8000_0001, 32'd4, 1'b0, 32'h0000_0010, 32'h8);
        drive("shr",    1'b0, 4'd11, 32'h8000_0001, 32'd4, 1'b0, 32'h0800_0000, 32'h1000_0000);
        drive("shl32",  1'b0, 4'd10, 32'h8000_0001, 32'd32, 1'b0, 32'h0, 32'h8000_0001);
        drive("shl63",  1'b0, 4'd10, 32'h8000_0001, 32'd63, 1'b0, 32'h0, 32'h8000_0000);
        drive("shl64",  1'b0, 4'd10, 32'h8000_0001, 32'd64, 1'b0, 32'h0, 32'h0);
        drive("shr64",  1'b0, 4'd11, 32'h8000_0001, 32'd64, 1'b0, 32'h0, 32'h0);
        drive("shrbig", 1'b0, 4'd11, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
        drive("midrst", 1'b1, 4'd7, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'h0, 32'h0);
        drive("postrst",1'b0, 4'd0, 32'h10, 32'h20, 1'b0, 32'h30, 32'h0);
        for (int i = 12; i < 16; i++)
            drive($sformatf("rsvd%0d", i), 1'b0, i[3:0], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                  32'h0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom();
            rb = $urandom();
            if (op == 4'd10 || op == 4'd11) rb = $urandom_range(0, 70);
            if (op == 4'd5 && $urandom_range(0, 7) == 0) rb = '0;
            if (op == 4'd5 && $urandom_range(0, 3) == 0) rb = $urandom_range(1, 300);
            drive_model($sformatf("rnd%0d_op%0d", i, op), op, ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

Parameterised, registered integer ALU for the datapath: one of twelve arithmetic, logic or shift operations on two WIDTH-bit operands plus a carry/borrow input. It produces a WIDTH-bit primary result `out` and a WIDTH-bit secondary result `extra`, which carries the carry/borrow, the high product word, the remainder or the shifted-out bits. Results are registered, so there is one cycle of latency between the sampling edge and the visible result.

## Interface
- `WIDTH`, default 32. Operand and result width; must be a multiple of 4 and at least 4.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `opcode`  input  4  operation select.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `carryin`  input  1  carry/borrow input.
- `out`  output  WIDTH  registered primary result.
- `extra`  output  WIDTH  registered secondary result.

## Operation
All arithmetic is unsigned. Carry and borrow flags are returned as `extra = {WIDTH-1 zeros, flag}`.

| opcode | op | `out` | `extra` |
|---|---|---|---|
| 0 | ADD | `a+b` mod 2^W | carry out |
| 1 | ADDC | `a+b+carryin` | carry out |
| 2 | SUB | `a-b` mod 2^W | borrow (1 iff `a<b`) |
| 3 | SUBB | `a-b-carryin` | borrow (1 iff `a < b+carryin`) |
| 4 | MUL | low W bits of the 2W-bit product | high W bits |
| 5 | DIV | `a/b` | `a%b` |
| 6 | AND | `a&b` | 0 |
| 7 | OR | `a\|b` | 0 |
| 8 | XOR | `a^b` | 0 |
| 9 | NOT | `~a` (`b` ignored) | 0 |
| 10 | SHL | `{extra,out} = {W'0,a} << b` | bits shifted out |
| 11 | SHR | `{out,extra} = {a,W'0} >> b` | bits shifted out (MSB-aligned) |
| 12–15 | reserved | 0 | 0 |

- DIV with `b==0`: `out` = all ones, `extra = a`.
- Shift amount is the full value of `b`. For `b >= 2*WIDTH` both `out` and `extra` are 0.
- `carryin` is ignored by every opcode except 1 and 3.

## Timing
- Inputs are sampled on each rising edge of `clk`. `out`/`extra` reflect that edge's inputs after the edge: 1-cycle latency, full throughput, no handshake.
- `rst=1` at an edge forces `out=0` and `extra=0`, overriding the operation.
- Reset mid-stream discards the in-flight result. The first post-reset result appears one edge after `rst` deasserts.
- Combinational paths (MUL, DIV) must settle within one clock period; no multicycle paths.
- Outputs never change except on a rising edge.

## Structure
- Shared package `alu_pkg` holds the opcode localparams: `OP_ADD`=0 … `OP_SHR`=11.
- Natural split:
  - combinational sub-module `alu_core`: opcode/a/b/carryin to next_out/next_extra.
  - wrapper `alu`: holds the output registers and reset.

## Test plan
WIDTH=32 throughout.
- ADD/ADDC: a=0xAAAAAAAA, b=0x55555555, cin=0, op0 → out=0xFFFFFFFF, extra=0. a=b=0x66666666, cin=1, op1 → out=0xCCCCCCCD, extra=0. a=0xFFFFFFFF, b=1, op0 → out=0, extra=1.
- SUB/SUBB: a=0xAAAAAAAA, b=0x55555555, op2 → out=0x55555555, extra=0. a=b=0x66666666, cin=1, op3 → out=0xFFFFFFFF, extra=1.
- MUL/DIV:
  - a=0xFFFFFFFF, b=2, op4 → out=0xFFFFFFFE, extra=1.
  - a=0xAAAAAAAA, b=0x55555555, op5 → out=2, extra=0.
  - a=7, b=0, op5 → out=0xFFFFFFFF, extra=7.
- Logic:
  - a=0xAAAAAAAA, b=0x55555555: op6 → 0; op7 → 0xFFFFFFFF; op8 → 0xFFFFFFFF; op9 → 0x55555555.
  - a=b=0x66666666, op8 → 0.
- Shifts:
  - a=0x80000001, b=4, op10 → out=0x00000010, extra=0x8.
  - same inputs, op11 → out=0x08000000, extra=0x10000000.
  - b=64 → both outputs 0.
- Reset/latency/reserved:
  - a result appears exactly one edge after the inputs are applied.
  - `rst` asserted mid-stream → outputs 0 on that edge.
  - opcode 12–15 → both outputs 0.
